// File: rtl/regsel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regsel_pkg
// Description : Shared encodings for the sequenced register selector:
//               transfer commands, OE/load index source selects, FSM states,
//               and helpers telling which indices a command uses.
// Revision    : 1.0 - initial release
// ============================================================================
package regsel_pkg;

  // Transfer commands
  localparam logic [1:0] CMD_NOP       = 2'd0;
  localparam logic [1:0] CMD_OE_ONLY   = 2'd1;
  localparam logic [1:0] CMD_LOAD_ONLY = 2'd2;
  localparam logic [1:0] CMD_MOVE      = 2'd3;

  // OE index sources
  localparam logic [1:0] OE_SRC_USEQ = 2'd0;
  localparam logic [1:0] OE_SRC_OP0  = 2'd1;
  localparam logic [1:0] OE_SRC_OP1  = 2'd2;
  localparam logic [1:0] OE_SRC_OP2  = 2'd3;

  // Load index sources
  localparam logic LOAD_SRC_USEQ = 1'b0;
  localparam logic LOAD_SRC_OP0  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    STROBE = 2'd2
  } state_t;

  function automatic logic cmdUsesOe(input logic [1:0] cmd);
    return (cmd == CMD_OE_ONLY) || (cmd == CMD_MOVE);
  endfunction

  function automatic logic cmdUsesLoad(input logic [1:0] cmd);
    return (cmd == CMD_LOAD_ONLY) || (cmd == CMD_MOVE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regsel_decoder.sv
`default_nettype none
// ============================================================================
// Module      : regsel_decoder
// Description : Index to active-low one-hot decoder. All ones when disabled.
//               Index values >= REG_COUNT match no bit.
// Ports       : enable    in  1          decode enable
//               index     in  SEL_W      register index
//               notOneHot out REG_COUNT  active-low one-hot vector
// Revision    : 1.0 - initial release
// ============================================================================
module regsel_decoder #(
  parameter int REG_COUNT = 8,
  parameter int SEL_W     = $clog2(REG_COUNT)
) (
  input  logic                 enable,
  input  logic [SEL_W-1:0]     index,
  output logic [REG_COUNT-1:0] notOneHot
);

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_bit
    assign notOneHot[i] = ~(enable && (index == SEL_W'(i)));
  end

endmodule
`default_nettype wire

// File: rtl/regsel_seq.sv
`default_nettype none
// ============================================================================
// Module      : regsel_seq
// Description : Sequenced register selector. Muxes an OE index and a load
//               index from their sources, checks them against REG_COUNT and
//               runs IDLE -> DRIVE (bus settle) -> STROBE, driving registered
//               active-low one-hot OE/load strobes to the register file.
// Ports       : clock, reset               clock / sync active-high reset
//               start, cmd                 transfer request and command
//               oeSourceSel, loadSourceSel index source selects
//               useqRegSelOE, useqRegSelLoad, op0, op1, op2  candidate indices
//               regNotOEs, regNotLoads     active-low one-hot strobes
//               busy, done, err            status / handshake
// Revision    : 1.0 - initial release
// ============================================================================
module regsel_seq
  import regsel_pkg::*;
#(
  parameter int REG_COUNT     = 8,
  parameter int SEL_W         = $clog2(REG_COUNT),
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           cmd,
  input  logic [1:0]           oeSourceSel,
  input  logic                 loadSourceSel,
  input  logic [SEL_W-1:0]     useqRegSelOE,
  input  logic [SEL_W-1:0]     useqRegSelLoad,
  input  logic [SEL_W-1:0]     op0,
  input  logic [SEL_W-1:0]     op1,
  input  logic [SEL_W-1:0]     op2,
  output logic [REG_COUNT-1:0] regNotOEs,
  output logic [REG_COUNT-1:0] regNotLoads,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cntLoad = CNT_W'(SETTLE_CYCLES - 1);

  state_t               r_state, w_nextState;
  logic [CNT_W-1:0]     r_cnt, w_cntNext;
  logic [SEL_W-1:0]     r_oeIdx, r_loadIdx;
  logic [1:0]           r_cmd;
  logic [REG_COUNT-1:0] r_notOEs, r_notLoads;
  logic                 r_done, r_err;

  logic [SEL_W-1:0]     w_muxOeIdx, w_muxLoadIdx;
  logic                 w_oeValid, w_loadValid, w_reject;
  logic                 w_capture, w_err;
  logic [1:0]           w_effCmd;
  logic [SEL_W-1:0]     w_effOeIdx, w_effLoadIdx;
  logic                 w_oeEn, w_loadEn;
  logic [REG_COUNT-1:0] w_oeVec, w_loadVec;

  // ---------------- source muxes ----------------
  always_comb begin
    w_muxOeIdx = useqRegSelOE;
    case (oeSourceSel)
      OE_SRC_USEQ: w_muxOeIdx = useqRegSelOE;
      OE_SRC_OP0:  w_muxOeIdx = op0;
      OE_SRC_OP1:  w_muxOeIdx = op1;
      OE_SRC_OP2:  w_muxOeIdx = op2;
      default:     w_muxOeIdx = useqRegSelOE;
    endcase
  end

  assign w_muxLoadIdx = (loadSourceSel == LOAD_SRC_OP0) ? op0 : useqRegSelLoad;

  // ---------------- index validity ----------------
  // With a power-of-two register count every encodable index is in range.
  if ((1 << SEL_W) == REG_COUNT) begin : g_fullRange
    assign w_oeValid   = 1'b1;
    assign w_loadValid = 1'b1;
  end else begin : g_partialRange
    localparam logic [SEL_W:0] c_regLimit = (SEL_W + 1)'(REG_COUNT);
    assign w_oeValid   = {1'b0, w_muxOeIdx}   < c_regLimit;
    assign w_loadValid = {1'b0, w_muxLoadIdx} < c_regLimit;
  end

  // Only the indices the command actually uses can cause a rejection.
  assign w_reject = (cmdUsesOe(cmd)   && !w_oeValid) ||
                    (cmdUsesLoad(cmd) && !w_loadValid);

  // ---------------- FSM next state ----------------
  always_comb begin
    w_nextState = r_state;
    w_cntNext   = r_cnt;
    w_capture   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          if (w_reject) begin
            w_err = 1'b1;
          end else begin
            case (cmd)
              CMD_OE_ONLY, CMD_MOVE: begin
                w_nextState = DRIVE;
                w_cntNext   = c_cntLoad;
              end
              CMD_LOAD_ONLY: w_nextState = STROBE;
              default:       w_nextState = IDLE;
            endcase
          end
        end
      end
      DRIVE: begin
        if (r_cnt != '0) begin
          w_cntNext = r_cnt - CNT_W'(1);
        end else begin
          w_nextState = STROBE;
        end
      end
      STROBE:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Strobes are registered, so they are decoded from the state being entered
  // and from the indices that will be held there (fresh on capture).
  assign w_effCmd     = w_capture ? cmd          : r_cmd;
  assign w_effOeIdx   = w_capture ? w_muxOeIdx   : r_oeIdx;
  assign w_effLoadIdx = w_capture ? w_muxLoadIdx : r_loadIdx;

  assign w_oeEn   = (w_nextState == DRIVE) ||
                    ((w_nextState == STROBE) && cmdUsesOe(w_effCmd));
  assign w_loadEn = (w_nextState == STROBE) && cmdUsesLoad(w_effCmd);

  regsel_decoder #(
    .REG_COUNT (REG_COUNT),
    .SEL_W     (SEL_W)
  ) u_oeDec (
    .enable    (w_oeEn),
    .index     (w_effOeIdx),
    .notOneHot (w_oeVec)
  );

  regsel_decoder #(
    .REG_COUNT (REG_COUNT),
    .SEL_W     (SEL_W)
  ) u_loadDec (
    .enable    (w_loadEn),
    .index     (w_effLoadIdx),
    .notOneHot (w_loadVec)
  );

  // ---------------- registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_oeIdx    <= '0;
      r_loadIdx  <= '0;
      r_cmd      <= CMD_NOP;
      r_notOEs   <= '1;
      r_notLoads <= '1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_cntNext;
      if (w_capture) begin
        r_oeIdx   <= w_muxOeIdx;
        r_loadIdx <= w_muxLoadIdx;
        r_cmd     <= cmd;
      end
      r_notOEs   <= w_oeVec;
      r_notLoads <= w_loadVec;
      r_done     <= (w_nextState == STROBE);
      r_err      <= w_err;
    end
  end

  assign regNotOEs   = r_notOEs;
  assign regNotLoads = r_notLoads;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign err         = r_err;

endmodule
`default_nettype wire
